// File: rtl/mem_ctrl_if.sv
// Requester and RAM-side bus of the byte-serial memory controller.
// Ports: LSB load/store, IF word fetch, 8-bit RAM/IO port.
// slave = controller side; master = requesters plus RAM.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              lsb_enable;
    logic [2:0]        lsb_size;
    logic [ADDR_W-1:0] lsb_addr;
    logic [31:0]       lsb_wdata;
    logic              lsb_wr_tag;
    logic              lsb_success;
    logic [31:0]       lsb_rdata;

    logic              if_enable;
    logic [ADDR_W-1:0] if_addr;
    logic              if_success;
    logic [31:0]       if_rdata;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    modport slave (
        input  lsb_enable, lsb_size, lsb_addr,
        input  lsb_wdata, lsb_wr_tag,
        output lsb_success, lsb_rdata,
        input  if_enable, if_addr,
        output if_success, if_rdata,
        input  mem_din,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output lsb_enable, lsb_size, lsb_addr,
        output lsb_wdata, lsb_wr_tag,
        input  lsb_success, lsb_rdata,
        output if_enable, if_addr,
        input  if_success, if_rdata,
        output mem_din,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates LSB and IF onto one 8-bit port.
// Ports: clk, rst (async active-low), rdy, jump_flag, io_buffer_full, bus.
// Optional macro IO_FULL_STALL_EN holds IO write beats while the UART is full.
module mem_ctrl #(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       jump_flag,
    input  logic       io_buffer_full,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_own_if;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_len;
    logic [2:0]        r_cnt;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_cap_v;
    logic [1:0]        r_cap_k;

    logic              w_acc_lsb;
    logic              w_acc_if;
    logic [ADDR_W-1:0] w_beat_a;
    logic              w_rd_issue;
    logic              w_rd_step;
    logic              w_abort;
    logic              w_io_stall;
    logic              w_wr_beat;
    logic [2:0]        w_lsb_len;

    assign w_acc_lsb = rdy && (r_state == S_IDLE) && bus.lsb_enable;
    assign w_acc_if  = rdy && (r_state == S_IDLE) && !bus.lsb_enable
                       && bus.if_enable && !jump_flag;

    assign w_beat_a   = r_addr + ADDR_W'(r_cnt);
    assign w_rd_issue = (r_state == S_READ) && (r_cnt < r_len);
    // A flush only kills instruction fetches; LSB ops always complete.
    assign w_abort    = rdy && jump_flag && (r_state == S_READ) && r_own_if;
    assign w_rd_step  = w_rd_issue && rdy && !w_abort;

`ifdef IO_FULL_STALL_EN
    assign w_io_stall = (r_state == S_WRITE)
                        && (w_beat_a[17:16] == IO_HI)
                        && io_buffer_full;
`else
    // UART back-pressure is not honoured in this build.
    assign w_io_stall = 1'b0 & io_buffer_full;
`endif

    assign w_wr_beat = (r_state == S_WRITE) && rdy && !w_io_stall;

    always_comb begin
        w_lsb_len = 3'd1;
        unique case (1'b1)
            bus.lsb_size[2]: w_lsb_len = 3'd4;
            bus.lsb_size[1]: w_lsb_len = 3'd2;
            default:         w_lsb_len = 3'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.mem_a       = '0;
        bus.mem_dout    = 8'h00;
        bus.mem_wr      = 1'b0;
        bus.lsb_success = 1'b0;
        bus.if_success  = 1'b0;
        bus.lsb_rdata   = r_rdata;
        bus.if_rdata    = r_rdata;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc_lsb) begin
                    w_state_nxt = bus.lsb_wr_tag ? S_WRITE : S_READ;
                end else if (w_acc_if) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (w_rd_issue) begin
                    bus.mem_a = w_beat_a;
                end
                // Count == len is the extra cycle that captures the last byte.
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (rdy && (r_cnt == r_len)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_WRITE: begin
                bus.mem_a    = w_beat_a;
                bus.mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                bus.mem_wr   = w_wr_beat;
                if (w_wr_beat && (r_cnt == r_len - 3'd1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.lsb_success = rdy && !r_own_if;
                bus.if_success  = rdy && r_own_if;
                if (rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_own_if <= 1'b0;
            r_addr   <= '0;
            r_len    <= 3'd0;
            r_cnt    <= 3'd0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_cap_v  <= 1'b0;
            r_cap_k  <= 2'd0;
        end else begin
            // mem_din always answers last cycle's address, stalled or not,
            // so capture tracking runs even while rdy is low.
            r_cap_v <= w_rd_issue && !w_abort;
            r_cap_k <= r_cnt[1:0];
            if (r_cap_v) begin
                r_rdata[{r_cap_k, 3'b000} +: 8] <= bus.mem_din;
            end
            if (w_rd_step || w_wr_beat) begin
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_acc_lsb) begin
                r_own_if <= 1'b0;
                r_addr   <= bus.lsb_addr;
                r_len    <= w_lsb_len;
                r_wdata  <= bus.lsb_wdata;
                r_rdata  <= 32'h0;
                r_cnt    <= 3'd0;
            end else if (w_acc_if) begin
                r_own_if <= 1'b1;
                r_addr   <= bus.if_addr;
                r_len    <= 3'd4;
                r_rdata  <= 32'h0;
                r_cnt    <= 3'd0;
            end
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed cases plus random LSB/IF traffic.
// RAM and a byte-level reference memory live here; expectations come from them.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic jump_flag = 1'b0;
    logic io_buffer_full = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    int n_ifs = 0;

    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .jump_flag(jump_flag),
        .io_buffer_full(io_buffer_full),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] w = 32'h0;
        for (int k = 0; k < n; k++)
            w = w | (32'(ref_rd(a + 32'(k))) << (8 * k));
        return w;
    endfunction

    // RAM: one-cycle read latency, writes on mem_wr beats.
    always @(posedge clk) begin
        bus.mem_din <= ram_rd(bus.mem_a);
        if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    end

    always @(negedge clk) begin
        if (bus.if_success) n_ifs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic lsb_op(input string tag, input bit wr, input int n,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int jump_at, input int rdy_at, input int rdy_len,
                          input int full_len);
        logic [39:0] q_got[$];
        logic [31:0] exp_rd;
        logic [31:0] got_rd = 32'h0;
        logic [31:0] ea;
        logic [1:0]  hi = addr[17:16];
        int lat = -1;
        int wr_bad = 0;
        int a_bad = 0;
        int exp_lat;
        int io_st = 0;
`ifdef IO_FULL_STALL_EN
        if (wr && hi == 2'b11) io_st = full_len;
`endif
        exp_lat = (wr ? n + 1 : n + 2) + rdy_len + io_st;
        exp_rd = ref_word(addr, n);
        if (wr)
            for (int k = 0; k < n; k++)
                ref_mem[addr + 32'(k)] = 8'(wdata >> (8 * k));
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.lsb_enable = 1'b1;
                bus.lsb_wr_tag = wr;
                bus.lsb_addr   = addr;
                bus.lsb_wdata  = wdata;
                bus.lsb_size   = (n == 4) ? 3'b100 : (n == 2) ? 3'b010 : 3'b001;
            end
            rdy = !(rdy_len > 0 && c >= rdy_at && c < rdy_at + rdy_len);
            jump_flag = (c == jump_at);
            io_buffer_full = (full_len > 0 && c <= full_len);
            @(negedge clk);
            if (bus.mem_wr) begin
                if (!rdy) wr_bad++;
                q_got.push_back({bus.mem_a, bus.mem_dout});
            end
            if (!wr && rdy_len == 0 && c >= 1 && c <= n) begin
                ea = addr + 32'(c - 1);
                if (bus.mem_a !== ea) a_bad++;
            end
            if (bus.lsb_success) begin
                lat = c;
                got_rd = bus.lsb_rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.lsb_enable = 1'b0;
        rdy = 1'b1;
        jump_flag = 1'b0;
        io_buffer_full = 1'b0;
        @(negedge clk);
        chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/pulse"}, 32'(bus.lsb_success), 32'h0);
        if (wr) begin
            chk({tag, "/beats"}, 32'(q_got.size()), 32'(n));
            for (int k = 0; k < n && k < q_got.size(); k++)
                chk({tag, "/beat"}, q_got[k][31:0] ^ {q_got[k][39:8], q_got[k][7:0]},
                    q_got[k][31:0] ^ {addr + 32'(k), 8'(wdata >> (8 * k))});
            chk({tag, "/wr_gated"}, 32'(wr_bad), 32'h0);
        end else begin
            chk({tag, "/rdata"}, got_rd, exp_rd);
            if (rdy_len == 0) chk({tag, "/addr"}, 32'(a_bad), 32'h0);
        end
    endtask

    task automatic if_fetch(input string tag, input logic [31:0] addr);
        logic [31:0] exp = ref_word(addr, 4);
        logic [31:0] got = 32'h0;
        int lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.if_enable = 1'b1;
                bus.if_addr = addr;
            end
            @(negedge clk);
            if (bus.if_success) begin
                lat = c;
                got = bus.if_rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.if_enable = 1'b0;
        chk({tag, "/lat"}, 32'(lat), 32'd6);
        chk({tag, "/rdata"}, got, exp);
    endtask

    initial begin
        int lsb_lat;
        int if_lat;
        int ifs0;
        logic [31:0] lsb_got;
        logic [31:0] if_got;
        bus.lsb_enable = 1'b0;
        bus.lsb_size   = 3'b001;
        bus.lsb_addr   = 32'h0;
        bus.lsb_wdata  = 32'h0;
        bus.lsb_wr_tag = 1'b0;
        bus.if_enable  = 1'b0;
        bus.if_addr    = 32'h0;

        // Reset state
        @(negedge clk);
        chk("rst/mem_a", bus.mem_a, 32'h0);
        chk("rst/mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("rst/lsb_success", 32'(bus.lsb_success), 32'h0);
        chk("rst/lsb_rdata", bus.lsb_rdata, 32'h0);
        chk("rst/if_success", 32'(bus.if_success), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1. LW 0x100
        ram[32'h100] = 8'hEF; ram[32'h101] = 8'hBE;
        ram[32'h102] = 8'hAD; ram[32'h103] = 8'hDE;
        ref_mem[32'h100] = 8'hEF; ref_mem[32'h101] = 8'hBE;
        ref_mem[32'h102] = 8'hAD; ref_mem[32'h103] = 8'hDE;
        lsb_op("lw100", 1'b0, 4, 32'h100, 32'h0, -1, 0, 0, 0);

        // 2. SH 0x204, then read it back
        lsb_op("sh204", 1'b1, 2, 32'h204, 32'h1234ABCD, -1, 0, 0, 0);
        lsb_op("lw204", 1'b0, 4, 32'h204, 32'h0, -1, 0, 0, 0);

        // 3. LSB and IF rise together
        lsb_lat = -1;
        if_lat = -1;
        lsb_got = 32'h0;
        if_got = 32'h0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.lsb_enable = 1'b1; bus.lsb_wr_tag = 1'b0;
                bus.lsb_size = 3'b100; bus.lsb_addr = 32'h500;
                bus.if_enable = 1'b1; bus.if_addr = 32'h600;
            end
            if (lsb_lat >= 0) bus.lsb_enable = 1'b0;
            @(negedge clk);
            if (bus.lsb_success) begin lsb_lat = c; lsb_got = bus.lsb_rdata; end
            if (bus.if_success) begin if_lat = c; if_got = bus.if_rdata; break; end
        end
        @(posedge clk);
        #1;
        bus.lsb_enable = 1'b0;
        bus.if_enable = 1'b0;
        chk("arb/lsb_lat", 32'(lsb_lat), 32'd6);
        chk("arb/lsb_rdata", lsb_got, ref_word(32'h500, 4));
        chk("arb/if_lat", 32'(if_lat), 32'd13);
        chk("arb/if_rdata", if_got, ref_word(32'h600, 4));

        // 4. Flush during IF fetch of 0x40, then an LB issued the next cycle
        ifs0 = n_ifs;
        @(posedge clk);
        #1;
        bus.if_enable = 1'b1;
        bus.if_addr = 32'h40;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("jmp/beat0", bus.mem_a, 32'h40);
        @(posedge clk);
        #1;
        jump_flag = 1'b1;
        bus.if_enable = 1'b0;
        @(negedge clk);
        chk("jmp/beat1", bus.mem_a, 32'h41);
        lsb_op("jmp/lb_after", 1'b0, 1, 32'h77, 32'h0, -1, 0, 0, 0);
        chk("jmp/no_if_success", 32'(n_ifs - ifs0), 32'h0);
        lsb_op("jmp/lb_during", 1'b0, 1, 32'h88, 32'h0, 2, 0, 0, 0);
        if_fetch("if_after_jmp", 32'h40);

        // 5. SB to IO space while the UART buffer is full
        lsb_op("sb_io", 1'b1, 1, 32'h30000, 32'h41, -1, 0, 0, 5);

        // 6a. Reset in the middle of a LW
        @(posedge clk);
        #1;
        bus.lsb_enable = 1'b1; bus.lsb_wr_tag = 1'b0;
        bus.lsb_size = 3'b100; bus.lsb_addr = 32'h100;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst/mem_a", bus.mem_a, 32'h0);
        chk("mrst/mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("mrst/lsb_rdata", bus.lsb_rdata, 32'h0);
        chk("mrst/lsb_success", 32'(bus.lsb_success), 32'h0);
        bus.lsb_enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        lsb_op("mrst/lw", 1'b0, 4, 32'h100, 32'h0, -1, 0, 0, 0);

        // 6b. rdy low for 3 cycles during a SW
        lsb_op("sw_rdy", 1'b1, 4, 32'h300, 32'hCAFEF00D, -1, 2, 3, 0);
        lsb_op("lw_rdy", 1'b0, 4, 32'h300, 32'h0, -1, 0, 0, 0);

        // Address wrap past 0xFFFFFFFF
        lsb_op("lw_wrap", 1'b0, 4, 32'hFFFFFFFE, 32'h0, -1, 0, 0, 0);

        // Random traffic in a small window so loads hit earlier stores
        for (int i = 0; i < 24; i++) begin
            bit wr = 1'($urandom_range(0, 1));
            int n = 1 << $urandom_range(0, 2);
            logic [31:0] a = 32'h1000 + 32'($urandom_range(0, 31));
            logic [31:0] d = $urandom;
            int rl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            if ($urandom_range(0, 3) == 0) if_fetch("rnd_if", a);
            lsb_op(wr ? "rnd_st" : "rnd_ld", wr, n, a, d, -1, 2, rl, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
